// File: rtl/piso_serializer.sv
// piso_serializer: accepts a WIDTH-bit word over valid/ready and shifts it out one bit per clock
// with a serial valid strobe and a last-bit marker; back-to-back words stream with no gap.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic             D_VALID,
  output logic             D_READY,
  output logic             SOUT,
  output logic             SVALID,
  output logic             SLAST,
  output logic             BUSY
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sout_q, sout_d, svalid_q, svalid_d, slast_q, slast_d, rdy_q, rdy_d;
  logic accept, step;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      cnt_q    <= '0;
      sout_q   <= 1'b0;
      svalid_q <= 1'b0;
      slast_q  <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      sout_q   <= sout_d;
      svalid_q <= svalid_d;
      slast_q  <= slast_d;
      rdy_q    <= rdy_d;
    end
  end
  // The shift register holds only the bits still to be sent; the current bit already sits in sout_q.
  always_comb begin
    accept   = D_VALID && rdy_q;
    step     = (state_q == SHIFT) && (cnt_q != '0);
    state_d  = (accept || step) ? SHIFT : IDLE;
    sr_d     = accept ? (MSB_FIRST ? D << 1 : D >> 1)
             : step   ? (MSB_FIRST ? sr_q << 1 : sr_q >> 1) : '0;
    sout_d   = accept ? (MSB_FIRST ? D[WIDTH-1] : D[0])
             : step   ? (MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0]) : 1'b0;
    cnt_d    = accept ? CW'(WIDTH - 1) : step ? cnt_q - 1'b1 : '0;
    svalid_d = accept || step;
    slast_d  = step && (cnt_q == CW'(1));
    rdy_d    = !(accept || step) || slast_d;
  end
  assign D_READY = rdy_q;
  assign SOUT    = sout_q;
  assign SVALID  = svalid_q;
  assign SLAST   = slast_q;
  assign BUSY    = svalid_q;
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: LSB-first and MSB-first instances share stimulus; a queue-of-bits model
// predicts every output each cycle, and serial logs pin the model against hand-computed words.
module tb_piso_serializer;
  localparam int W = 4;
  logic clk = 1'b0, rst = 1'b0;
  logic [W-1:0] d = '0;
  logic dv = 1'b0;
  logic rdy0, sout0, sv0, sl0, busy0;
  logic rdy1, sout1, sv1, sl1, busy1;
  int errors = 0, checks = 0;
  logic [1:0] q0[$], q1[$];
  logic es[2] = '{1'b0, 1'b0};
  logic ev[2] = '{1'b0, 1'b0};
  logic el[2] = '{1'b0, 1'b0};
  logic er[2] = '{1'b1, 1'b1};
  logic [15:0] log0 = '0, ll0 = '0, lr0 = '0, log1 = '0, ll1 = '0;
  int n0 = 0, n1 = 0;
  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .CLK(clk), .RST(rst), .D(d), .D_VALID(dv), .D_READY(rdy0),
    .SOUT(sout0), .SVALID(sv0), .SLAST(sl0), .BUSY(busy0));
  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .CLK(clk), .RST(rst), .D(d), .D_VALID(dv), .D_READY(rdy1),
    .SOUT(sout1), .SVALID(sv1), .SLAST(sl1), .BUSY(busy1));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  // Model: an accepted word becomes WIDTH queued {bit,last} entries; each cycle shows the head.
  always @(posedge clk or posedge rst) begin
    logic [1:0] e;
    if (rst) begin
      q0.delete();
      q1.delete();
      for (int i = 0; i < 2; i++) begin
        es[i] = 1'b0; ev[i] = 1'b0; el[i] = 1'b0; er[i] = 1'b1;
      end
    end else begin
      if (dv && er[0]) for (int k = 0; k < W; k++) q0.push_back({d[k], k == W - 1});
      if (dv && er[1]) for (int k = 0; k < W; k++) q1.push_back({d[W-1-k], k == W - 1});
      if (q0.size() > 0) begin
        e = q0.pop_front();
        es[0] = e[1]; el[0] = e[0]; ev[0] = 1'b1; er[0] = e[0];
      end else begin
        es[0] = 1'b0; el[0] = 1'b0; ev[0] = 1'b0; er[0] = 1'b1;
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        es[1] = e[1]; el[1] = e[0]; ev[1] = 1'b1; er[1] = e[0];
      end else begin
        es[1] = 1'b0; el[1] = 1'b0; ev[1] = 1'b0; er[1] = 1'b1;
      end
    end
  end
  always @(negedge clk) begin
    chk("lsb_ready", 32'(rdy0), 32'(er[0]));
    chk("lsb_sout", 32'(sout0), 32'(es[0]));
    chk("lsb_svalid", 32'(sv0), 32'(ev[0]));
    chk("lsb_slast", 32'(sl0), 32'(el[0]));
    chk("lsb_busy", 32'(busy0), 32'(ev[0]));
    chk("msb_ready", 32'(rdy1), 32'(er[1]));
    chk("msb_sout", 32'(sout1), 32'(es[1]));
    chk("msb_svalid", 32'(sv1), 32'(ev[1]));
    chk("msb_slast", 32'(sl1), 32'(el[1]));
    chk("msb_busy", 32'(busy1), 32'(ev[1]));
    if (sv0) begin
      log0 = {log0[14:0], sout0}; ll0 = {ll0[14:0], sl0}; lr0 = {lr0[14:0], rdy0}; n0++;
    end
    if (sv1) begin
      log1 = {log1[14:0], sout1}; ll1 = {ll1[14:0], sl1}; n1++;
    end
  end
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  initial begin
    int s, s2;
    #1 rst = 1'b1;
    #12 rst = 1'b0;
    s = n0;
    cycles(5);
    chk("reset_idle_count", 32'(n0 - s), 32'd0);
    chk("reset_ready_lit", 32'(rdy0), 32'd1);
    // single word 1011: LSB shows 1,1,0,1 and MSB shows 1,0,1,1
    s = n0;
    d = 4'b1011; dv = 1'b1;
    cycles(1);
    dv = 1'b0;
    cycles(6);
    chk("single_count", 32'(n0 - s), 32'd4);
    chk("single_lsb_bits", 32'(log0[3:0]), 32'b1101);
    chk("single_lsb_last", 32'(ll0[3:0]), 32'b0001);
    chk("single_lsb_ready", 32'(lr0[3:0]), 32'b0001);
    chk("single_msb_bits", 32'(log1[3:0]), 32'b1011);
    // MSB-first 1000 -> 1,0,0,0
    d = 4'b1000; dv = 1'b1;
    cycles(1);
    dv = 1'b0;
    cycles(6);
    chk("msb_bits", 32'(log1[3:0]), 32'b1000);
    chk("msb_last", 32'(ll1[3:0]), 32'b0001);
    // back-to-back A then 5, valid held through the second accept
    s = n0;
    d = 4'hA; dv = 1'b1;
    cycles(1);
    cycles(3);
    d = 4'h5;
    cycles(1);
    dv = 1'b0;
    cycles(8);
    chk("b2b_count", 32'(n0 - s), 32'd8);
    chk("b2b_bits", 32'(log0[7:0]), 32'h5A);
    chk("b2b_last", 32'(ll0[7:0]), 32'b0001_0001);
    chk("b2b_ready", 32'(lr0[7:0]), 32'b0001_0001);
    // D changed to 0 mid-word with valid held: F goes out intact, then the 0 word
    s = n0;
    d = 4'hF; dv = 1'b1;
    cycles(1);
    d = 4'h0;
    cycles(4);
    dv = 1'b0;
    cycles(8);
    chk("midchg_count", 32'(n0 - s), 32'd8);
    chk("midchg_bits", 32'(log0[7:0]), 32'hF0);
    // asynchronous reset during the second bit
    s = n0;
    d = 4'h6; dv = 1'b1;
    @(posedge clk);
    #2 dv = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_svalid", 32'(sv0), 32'd0);
    chk("arst_slast", 32'(sl0), 32'd0);
    chk("arst_busy", 32'(busy0), 32'd0);
    chk("arst_ready", 32'(rdy0), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    s2 = n0;
    cycles(6);
    chk("arst_bits_before", 32'(s2 - s), 32'd1);
    chk("arst_no_resend", 32'(n0 - s2), 32'd0);
    // randomized traffic with occasional asynchronous reset pulses
    for (int i = 0; i < 600; i++) begin
      dv = ($urandom_range(0, 3) != 0);
      d = W'($urandom);
      if ($urandom_range(0, 79) == 0) begin
        rst = 1'b1;
        #1 rst = 1'b0;
      end
      cycles(1);
    end
    dv = 1'b0;
    cycles(6);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in, serial-out transmitter. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock, with a serial valid strobe and a last-bit marker. It is the read-out counterpart to the team's parallel D-register banks: words captured in a register bank leave the block serially toward a downstream deserializer.

Parameters:
WIDTH, 4, word width in bits; legal range 2..32.
MSB_FIRST, 0, 0 = shift LSB first, 1 = shift MSB first.

Ports:
CLK  input  1  system clock; all state updates on the rising edge.
RST  input  1  reset, asynchronous, active-high.
D  input  WIDTH  parallel word to transmit.
D_VALID  input  1  D holds a word to send.
D_READY  output  1  block can accept a word this cycle.
SOUT  output  1  serial data bit.
SVALID  output  1  SOUT carries a valid bit this cycle.
SLAST  output  1  current SOUT bit is the final bit of the word.
BUSY  output  1  a word is in flight.

Behaviour:
- Interface (already decided): one clock, CLK; reset is RST, asynchronous and active-high. Asserting RST immediately forces the reset values below, regardless of CLK.
- Reset values: D_READY=1, SOUT=0, SVALID=0, SLAST=0, BUSY=0; shift register=0; bit counter=0; state=IDLE.
- All outputs are registered. None of them depends combinationally on the inputs.
- States: IDLE and SHIFT.
- IDLE:
  - D_READY=1, SVALID=0, SOUT=0.
  - When D_VALID=1 on a rising edge, load D into the shift register, set the counter to WIDTH-1, and go to SHIFT.
  - On that same edge, drive SOUT with the first bit (D[0], or D[WIDTH-1] when MSB_FIRST=1), set SVALID=1, and drop D_READY to 0.
  - Latency: the first bit appears on the cycle after the accept edge.
- SHIFT:
  - Each edge shifts out the next bit and decrements the counter. SVALID stays 1.
  - SLAST=1 exactly on the cycle that carries the final bit, which is bit WIDTH of WIDTH.
  - One word occupies exactly WIDTH consecutive SVALID cycles.
  - D_VALID and D are ignored while in SHIFT. The loaded copy is the only one used; changing D mid-word has no effect.
- Back-to-back transfers:
  - D_READY rises to 1 on the same edge that puts the last bit on SOUT, so D_READY=1 and SLAST=1 are visible together.
  - If D_VALID=1 on the next edge, the new word's first bit follows immediately. SVALID stays high with no gap, and SLAST=0 for that bit.
  - If D_VALID=0 on that edge, go to IDLE. SVALID and SLAST clear, and SOUT returns to 0.
- Handshake:
  - A transfer occurs only on an edge where D_VALID=1 and D_READY=1.
  - The upstream may hold D_VALID high indefinitely; each accept consumes exactly one word.
- BUSY = 1 whenever SVALID=1.
- Reset mid-word: the word is abandoned and the outputs take their reset values asynchronously. After RST releases, the block is in IDLE; nothing is retransmitted.
- Counter width is clog2(WIDTH). The counter never wraps below 0; reaching 0 ends the word.

Test Plan:
- Reset: RST=1 at time 0, then released; D_VALID=0 for 5 cycles -> D_READY=1, SVALID=0, SOUT=0, BUSY=0 throughout.
- Single word, LSB first: WIDTH=4, MSB_FIRST=0, D=4'b1011 with a one-cycle D_VALID pulse -> SOUT sequence 1,1,0,1 on 4 consecutive SVALID cycles starting the cycle after accept; SLAST only on the 4th bit; D_READY=0 for the first 3 bit cycles.
- MSB first: MSB_FIRST=1, D=4'b1000 -> SOUT 1,0,0,0; SLAST on the 4th bit.
- Back-to-back: D_VALID held high with D=4'hA, then 4'h5 presented on the accept cycle of the second word -> 8 contiguous SVALID cycles with SOUT 0,1,0,1,1,0,1,0 (LSB first); SLAST on cycles 4 and 8; D_READY=1 on cycles 4 and 8.
- D change mid-word: accept D=4'hF, then drive D=4'h0 with D_VALID=1 during the shift -> serial output stays 1,1,1,1; the next word begins only after SLAST.
- Async reset mid-word: assert RST between clock edges during the 2nd bit -> SVALID, SLAST and BUSY clear immediately and D_READY=1; after release with D_VALID=0, no further SVALID.
